// File: rtl/i2c_bus_conditioner.sv
// I2C bus conditioner: synchronises and glitch-filters the raw SCL/SDA pad
// reads, then derives single-cycle bus events (SCL edges, START, repeated
// START, STOP), a bus-busy flag and a sticky SCL-stuck-low timeout.

// One pad line: synchroniser chain followed by a consecutive-sample filter.
module i2c_line_filter #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pad_i,
  output logic level_o
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic [3:0]             cnt_q;
  logic                   sample;

  assign sample = sync_q[SYNC_STAGES-1];

  // Synchroniser chain; idle bus level is high, so reset to ones.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= '1;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], pad_i};
  end

  // Flip the level only after FILTER_CYCLES consecutive differing samples.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      level_o <= 1'b1;
      cnt_q   <= '0;
    end else if (sample == level_o) begin
      cnt_q <= '0;
    end else if (cnt_q == 4'(FILTER_CYCLES - 1)) begin
      level_o <= sample;
      cnt_q   <= '0;
    end else begin
      cnt_q <= cnt_q + 4'd1;
    end
  end
endmodule

module i2c_bus_conditioner #(
  parameter int          SYNC_STAGES    = 2,
  parameter int          FILTER_CYCLES  = 4,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd675000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_o,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic rstart_o,
  output logic stop_o,
  output logic busy_o,
  output logic timeout_o
);
  logic [1:0]  pad, lvl;
  logic        scl_prev_q, sda_prev_q;
  logic        start_det, stop_det, to_hit;
  logic [31:0] to_cnt_q;

  // Lane 0 is SCL, lane 1 is SDA.
  assign pad = {sda_i, scl_i};

  for (genvar i = 0; i < 2; i++) begin : g_line
    i2c_line_filter #(
      .SYNC_STAGES  (SYNC_STAGES),
      .FILTER_CYCLES(FILTER_CYCLES)
    ) u_filt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .pad_i  (pad[i]),
      .level_o(lvl[i])
    );
  end

  assign scl_o = lvl[0];
  assign sda_o = lvl[1];

  // SDA transitions only count as START/STOP when SCL was steadily high,
  // so a simultaneous SCL+SDA change yields just the SCL edge.
  assign start_det = scl_o & scl_prev_q &  sda_prev_q & ~sda_o;
  assign stop_det  = scl_o & scl_prev_q & ~sda_prev_q &  sda_o;
  assign to_hit    = busy_o & ~scl_o & (to_cnt_q == TIMEOUT_CYCLES - 32'd1);

  // Previous filtered levels and registered one-cycle event pulses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      scl_rise_o <= 1'b0;
      scl_fall_o <= 1'b0;
      start_o    <= 1'b0;
      rstart_o   <= 1'b0;
      stop_o     <= 1'b0;
    end else begin
      scl_prev_q <= scl_o;
      sda_prev_q <= sda_o;
      scl_rise_o <= scl_o & ~scl_prev_q;
      scl_fall_o <= ~scl_o & scl_prev_q;
      start_o    <= start_det;
      rstart_o   <= start_det & busy_o;
      stop_o     <= stop_det;
    end
  end

  // Bus ownership, SCL-low timeout counter and sticky timeout flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_o    <= 1'b0;
      timeout_o <= 1'b0;
      to_cnt_q  <= '0;
    end else begin
      if (!busy_o || scl_o || to_hit) to_cnt_q <= '0;
      else                            to_cnt_q <= to_cnt_q + 32'd1;

      if (start_det) begin
        busy_o    <= 1'b1;
        timeout_o <= 1'b0;
      end else if (to_hit) begin
        busy_o    <= 1'b0;
        timeout_o <= 1'b1;
      end else if (stop_det) begin
        busy_o <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_i2c_bus_conditioner.sv
// Randomised bench for i2c_bus_conditioner with a behavioural bus model.
module tb_i2c_bus_conditioner;
  localparam int S = 2;
  localparam int F = 4;
  localparam int T = 100;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic scl_pad = 1'b1, sda_pad = 1'b1;
  logic scl_o, sda_o, scl_rise_o, scl_fall_o, start_o, rstart_o, stop_o, busy_o, timeout_o;

  i2c_bus_conditioner #(
    .SYNC_STAGES(S), .FILTER_CYCLES(F), .TIMEOUT_CYCLES(32'(T))
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .scl_i(scl_pad), .sda_i(sda_pad),
    .scl_o(scl_o), .sda_o(sda_o), .scl_rise_o(scl_rise_o), .scl_fall_o(scl_fall_o),
    .start_o(start_o), .rstart_o(rstart_o), .stop_o(stop_o),
    .busy_o(busy_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  logic [8:0] dut_vec;
  assign dut_vec = {scl_o, sda_o, scl_rise_o, scl_fall_o, start_o, rstart_o, stop_o, busy_o, timeout_o};

  int n_checks = 0, n_pass = 0;

  // Behavioural model: pad history window, filtered levels, bus state.
  logic [S+F-1:0] h_scl, h_sda;
  logic m_scl, m_sda, m_scl_d, m_sda_d;
  logic e_rise, e_fall, e_start, e_rstart, e_stop, e_busy, e_to;
  int   lowcnt;

  // Tallies collected while driving.
  int mm, n_rise, n_fall, n_start, n_rstart, n_stop, n_both, n_stop_busy, n_sda_low;
  logic [8:0] last_got, last_exp;

  function automatic logic [8:0] exp_vec();
    return {m_scl, m_sda, e_rise, e_fall, e_start, e_rstart, e_stop, e_busy, e_to};
  endfunction

  task automatic model_reset();
    h_scl = '1; h_sda = '1;
    m_scl = 1'b1; m_sda = 1'b1; m_scl_d = 1'b1; m_sda_d = 1'b1;
    e_rise = 0; e_fall = 0; e_start = 0; e_rstart = 0; e_stop = 0; e_busy = 0; e_to = 0;
    lowcnt = 0;
  endtask

  task automatic model_step(input logic s, input logic d);
    logic st, sp;
    // Events come from the filtered levels as they stood before this edge.
    st = m_scl & m_scl_d & m_sda_d & ~m_sda;
    sp = m_scl & m_scl_d & ~m_sda_d & m_sda;
    e_rise = m_scl & ~m_scl_d;
    e_fall = ~m_scl & m_scl_d;
    e_rstart = st & e_busy;
    e_start = st;
    e_stop = sp;
    if (st) begin
      e_busy = 1; e_to = 0; lowcnt = 0;
    end else if (e_busy && !m_scl) begin
      lowcnt++;
      if (lowcnt == T) begin e_to = 1; e_busy = 0; lowcnt = 0; end
    end else begin
      lowcnt = 0;
      if (sp) e_busy = 0;
    end
    m_scl_d = m_scl; m_sda_d = m_sda;
    // A level flips once the F samples seen by the filter (pads S..S+F-1
    // edges old) all differ from it.
    h_scl = {h_scl[S+F-2:0], s};
    h_sda = {h_sda[S+F-2:0], d};
    if (h_scl[S+F-1:S] == {F{~m_scl}}) m_scl = ~m_scl;
    if (h_sda[S+F-1:S] == {F{~m_sda}}) m_sda = ~m_sda;
  endtask

  task automatic clear_tally();
    mm = 0; n_rise = 0; n_fall = 0; n_start = 0; n_rstart = 0; n_stop = 0;
    n_both = 0; n_stop_busy = 0; n_sda_low = 0;
  endtask

  // Hold pads for n clocks, advancing the model and tallying DUT activity.
  task automatic drive(input logic s, input logic d, input int n);
    for (int i = 0; i < n; i++) begin
      scl_pad = s; sda_pad = d;
      @(posedge clk_i);
      if (!rst_ni) model_reset(); else model_step(s, d);
      #1;
      if (dut_vec !== exp_vec()) begin mm++; last_got = dut_vec; last_exp = exp_vec(); end
      n_rise      += int'(scl_rise_o);
      n_fall      += int'(scl_fall_o);
      n_start     += int'(start_o);
      n_rstart    += int'(rstart_o);
      n_stop      += int'(stop_o);
      n_both      += int'(start_o & rstart_o);
      n_stop_busy += int'(stop_o & busy_o);
      n_sda_low   += int'(!sda_o);
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    model_reset();
    repeat (3) @(posedge clk_i);
    #1;
    n_checks++;
    if (dut_vec !== 9'b110000000) $display("FAIL reset_state got=%b exp=%b", dut_vec, 9'b110000000);
    else n_pass++;
    rst_ni = 1'b1;
    clear_tally();
    drive(1, 1, 10);
    n_checks++;
    if (mm !== 0) $display("FAIL idle_model got=%b exp=%b", last_got, last_exp);
    else n_pass++;
  endtask

  task automatic test_glitch();
    int len;
    clear_tally();
    for (int r = 0; r < 2; r++) begin
      len = (r == 0) ? int'($urandom_range(1, 3)) : 3;
      drive(1, 0, len);
      drive(1, 1, 12);
    end
    n_checks++;
    if (n_sda_low !== 0 || n_start !== 0) $display("FAIL glitch_drop sda_low=%0d start=%0d exp=0/0", n_sda_low, n_start);
    else n_pass++;
    // Four-clock low pulse: sda_o falls after 6 clocks, START one clock later.
    for (int k = 1; k <= 8; k++) begin
      drive(1, 0, 1);
      if (k == 5 || k == 6 || k == 7) begin
        n_checks++;
        if (k == 5 && (sda_o !== 1'b1 || start_o !== 1'b0))
          $display("FAIL glitch_lat5 sda_o=%b start_o=%b exp=1/0", sda_o, start_o);
        else if (k == 6 && (sda_o !== 1'b0 || start_o !== 1'b0))
          $display("FAIL glitch_lat6 sda_o=%b start_o=%b exp=0/0", sda_o, start_o);
        else if (k == 7 && (start_o !== 1'b1 || busy_o !== 1'b1))
          $display("FAIL glitch_start7 start_o=%b busy_o=%b exp=1/1", start_o, busy_o);
        else n_pass++;
      end
    end
    drive(1, 1, 12);
    n_checks++;
    if (mm !== 0 || n_start !== 1 || n_stop !== 1 || busy_o !== 1'b0)
      $display("FAIL glitch_model mm=%0d start=%0d stop=%0d busy=%b got=%b exp=%b", mm, n_start, n_stop, busy_o, last_got, last_exp);
    else n_pass++;
  endtask

  task automatic test_byte();
    logic b, cur;
    clear_tally();
    drive(1, 0, 10);
    cur = 1'b0;
    for (int i = 0; i < 9; i++) begin
      b = (i == 8) ? 1'b0 : 1'($urandom_range(0, 1));
      drive(0, cur, 5);
      cur = b;
      drive(0, cur, 5);
      drive(1, cur, 10);
    end
    drive(1, 1, 12);
    n_checks++;
    if (n_start !== 1 || n_rise !== 9 || n_fall !== 9 || n_stop !== 1 || n_rstart !== 0)
      $display("FAIL byte_counts start=%0d rise=%0d fall=%0d stop=%0d rstart=%0d exp=1/9/9/1/0",
               n_start, n_rise, n_fall, n_stop, n_rstart);
    else n_pass++;
    n_checks++;
    if (n_stop_busy !== 0 || busy_o !== 1'b0) $display("FAIL byte_busy_drop stop_busy=%0d busy=%b exp=0/0", n_stop_busy, busy_o);
    else n_pass++;
    n_checks++;
    if (mm !== 0) $display("FAIL byte_model got=%b exp=%b", last_got, last_exp);
    else n_pass++;
  endtask

  task automatic test_rstart();
    clear_tally();
    drive(1, 0, 10);
    drive(0, 0, 5);
    drive(0, 1, 5);
    drive(1, 1, 10);
    drive(1, 0, 10);
    n_checks++;
    if (busy_o !== 1'b1 || n_rstart !== 1 || n_both !== 1 || n_start !== 2)
      $display("FAIL rstart busy=%b rstart=%0d both=%0d start=%0d exp=1/1/1/2", busy_o, n_rstart, n_both, n_start);
    else n_pass++;
    drive(0, 0, 10);
    drive(1, 0, 10);
    drive(1, 1, 12);
    n_checks++;
    if (mm !== 0 || n_stop !== 1 || busy_o !== 1'b0)
      $display("FAIL rstart_model mm=%0d stop=%0d busy=%b got=%b exp=%b", mm, n_stop, busy_o, last_got, last_exp);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    clear_tally();
    drive(0, 0, 10);
    n_checks++;
    if (n_fall !== 1 || n_start !== 0) $display("FAIL simul_fall fall=%0d start=%0d exp=1/0", n_fall, n_start);
    else n_pass++;
    drive(1, 1, 10);
    n_checks++;
    if (n_rise !== 1 || n_stop !== 0 || mm !== 0)
      $display("FAIL simul_rise rise=%0d stop=%0d mm=%0d exp=1/0/0", n_rise, n_stop, mm);
    else n_pass++;
  endtask

  task automatic test_timeout();
    clear_tally();
    drive(1, 0, 10);
    for (int k = 1; k <= 120; k++) begin
      drive(0, 0, 1);
      if (k == 105 || k == 106) begin
        n_checks++;
        if (k == 105 && (timeout_o !== 1'b0 || busy_o !== 1'b1))
          $display("FAIL timeout_pre timeout=%b busy=%b exp=0/1", timeout_o, busy_o);
        else if (k == 106 && (timeout_o !== 1'b1 || busy_o !== 1'b0))
          $display("FAIL timeout_hit timeout=%b busy=%b exp=1/0", timeout_o, busy_o);
        else n_pass++;
      end
    end
    drive(1, 0, 10);
    drive(1, 1, 10);
    n_checks++;
    if (n_stop !== 1 || timeout_o !== 1'b1) $display("FAIL timeout_sticky stop=%0d timeout=%b exp=1/1", n_stop, timeout_o);
    else n_pass++;
    for (int k = 1; k <= 8; k++) begin
      drive(1, 0, 1);
      if (k == 6 || k == 7) begin
        n_checks++;
        if (k == 6 && timeout_o !== 1'b1) $display("FAIL timeout_hold timeout=%b exp=1", timeout_o);
        else if (k == 7 && (timeout_o !== 1'b0 || busy_o !== 1'b1 || start_o !== 1'b1))
          $display("FAIL timeout_clear timeout=%b busy=%b start=%b exp=0/1/1", timeout_o, busy_o, start_o);
        else n_pass++;
      end
    end
    drive(1, 1, 12);
    n_checks++;
    if (mm !== 0) $display("FAIL timeout_model got=%b exp=%b", last_got, last_exp);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    clear_tally();
    drive(1, 0, 10);
    drive(0, 0, 10);
    drive(1, 0, 10);
    drive(0, 0, 3);
    rst_ni = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (dut_vec !== 9'b110000000) $display("FAIL reset_mid got=%b exp=%b", dut_vec, 9'b110000000);
    else n_pass++;
    drive(0, 0, 3);
    rst_ni = 1'b1;
    clear_tally();
    drive(0, 0, 10);
    drive(1, 0, 10);
    drive(1, 1, 10);
    n_checks++;
    if (n_fall !== 1 || n_rise !== 1 || n_start !== 0 || n_stop !== 1 || busy_o !== 1'b0)
      $display("FAIL reset_release fall=%0d rise=%0d start=%0d stop=%0d busy=%b exp=1/1/0/1/0",
               n_fall, n_rise, n_start, n_stop, busy_o);
    else n_pass++;
    drive(1, 0, 10);
    n_checks++;
    if (n_start !== 1 || busy_o !== 1'b1) $display("FAIL reset_restart start=%0d busy=%b exp=1/1", n_start, busy_o);
    else n_pass++;
    drive(1, 1, 12);
    n_checks++;
    if (mm !== 0) $display("FAIL reset_model got=%b exp=%b", last_got, last_exp);
    else n_pass++;
  endtask

  task automatic test_random();
    clear_tally();
    for (int i = 0; i < 300; i++)
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(1, 10)));
    drive(1, 1, 12);
    n_checks++;
    if (mm !== 0) $display("FAIL random_model mismatches=%0d got=%b exp=%b", mm, last_got, last_exp);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_byte();
    test_rstart();
    test_simultaneous();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
